// File: rtl/sram_scan_bridge_if.sv
// SRAM-side bus of the scan bridge: one access strobe per cycle, separate
// write/read data. The bridge uses the master view; the SRAM (or a model of
// it) uses the slave view.
//   mem_en     access strobe
//   mem_we     1 = write, 0 = read (qualified by mem_en)
//   mem_addr   word address
//   mem_wdata  write data
//   mem_rdata  read data, valid the cycle after a read strobe
interface sram_scan_bridge_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata,
                  input mem_rdata);
  modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/sram_scan_bridge.sv
// Serial-to-SRAM bridge. A 1-bit scan stream carries framed commands
// (start bit, OP[1:0], ADDR, COUNT, LSB first) that are executed as bursts of
// COUNT+1 words against a single-port synchronous SRAM: WRITE, READ, FILL, NOP.
// Ports:
//   scan_clk / scan_rst  clock, synchronous active-high reset
//   scan_in              serial command/data stream
//   scan_out             serial read data, qualified by scan_out_valid
//   busy                 high whenever a frame is in progress
//   cmd_done             one-cycle pulse when a command returns to idle
//   frame_err            sticky flag: a start address >= DEPTH was seen
//   mem                  SRAM bus (master side)
module sram_scan_bridge #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 2048
) (
  input  logic scan_clk,
  input  logic scan_rst,
  input  logic scan_in,
  output logic scan_out,
  output logic scan_out_valid,
  output logic busy,
  output logic cmd_done,
  output logic frame_err,
  sram_scan_bridge_if.master mem
);
  localparam int HDR_W  = 2 + ADDR_W + CNT_W;
  localparam int BC_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int BC_W   = $clog2(BC_MAX);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA, S_FILL, S_RREQ, S_RCAP, S_RSHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [HDR_W-2:0]  hdr_q, hdr_d;      // first HDR_W-1 header bits
  logic [DATA_W-2:0] wsr_q, wsr_d;      // first DATA_W-1 bits of a write word
  logic [DATA_W-1:0] rsr_q, rsr_d;      // read-back shift register
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;      // words (or fill writes) still to go
  logic              fill_q, fill_d;
  logic              cmd_err_q, cmd_err_d;
  logic              frame_err_q, frame_err_d;
  logic              cmd_done_q, cmd_done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Header and write word as they stand including the bit on scan_in now.
  logic [HDR_W-1:0]  hdr_full;
  logic [1:0]        hdr_op;
  logic [ADDR_W-1:0] hdr_addr;
  logic [CNT_W-1:0]  hdr_cnt;
  logic              hdr_bad, hdr_last, word_last, prefetch;
  logic [DATA_W-1:0] wword;

  assign hdr_full  = {scan_in, hdr_q};
  assign hdr_op    = hdr_full[1:0];
  assign hdr_addr  = hdr_full[2 +: ADDR_W];
  assign hdr_cnt   = hdr_full[2+ADDR_W +: CNT_W];
  assign hdr_bad   = ({1'b0, hdr_addr} >= DEPTH_EXT);
  assign hdr_last  = (bit_cnt_q == BC_W'(HDR_W-1));
  assign word_last = (bit_cnt_q == BC_W'(DATA_W-1));
  // Strobing the next read here puts its data on mem_rdata during the last
  // bit of the current word, so it can be loaded at the word boundary.
  assign prefetch  = (bit_cnt_q == BC_W'(DATA_W-3));
  assign wword     = {scan_in, wsr_q};

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] n;
    n = {1'b0, a} + 1'b1;
    return (n == DEPTH_EXT) ? '0 : n[ADDR_W-1:0];
  endfunction

  // State register and datapath flops
  always_ff @(posedge scan_clk) begin
    if (scan_rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      wsr_q       <= '0;
      rsr_q       <= '0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      fill_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      wsr_q       <= wsr_d;
      rsr_q       <= rsr_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
      cmd_err_q   <= cmd_err_d;
      frame_err_q <= frame_err_d;
      cmd_done_q  <= cmd_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (scan_in) state_d = S_HDR;
      S_HDR:
        if (hdr_last) begin
          case (hdr_op)
            2'b00:   state_d = S_IDLE;
            2'b10:   state_d = S_RREQ;
            default: state_d = S_WDATA;
          endcase
        end
      S_WDATA:
        if (word_last && rem_q == '0) state_d = S_IDLE;
        else if (word_last && fill_q) state_d = S_FILL;
      S_FILL:   if (rem_q == CNT_W'(1)) state_d = S_IDLE;
      S_RREQ:   state_d = S_RCAP;
      S_RCAP:   state_d = S_RSHIFT;
      S_RSHIFT: if (word_last && rem_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values; memory strobes are single-cycle pulses.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hdr_d       = hdr_q;
    wsr_d       = wsr_q;
    rsr_d       = rsr_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
    cmd_err_d   = cmd_err_q;
    frame_err_d = frame_err_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: bit_cnt_d = '0;
      S_HDR: begin
        hdr_d     = {scan_in, hdr_q[HDR_W-2:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (hdr_last) begin
          bit_cnt_d  = '0;
          cur_addr_d = hdr_addr;
          rem_d      = hdr_cnt;
          fill_d     = (hdr_op == 2'b11);
          cmd_err_d  = hdr_bad;
          if (hdr_bad) frame_err_d = 1'b1;
          if (hdr_op == 2'b10) begin
            // First read strobe lands in the RREQ cycle.
            mem_en_d   = ~hdr_bad;
            mem_addr_d = hdr_addr;
            cur_addr_d = addr_inc(hdr_addr);
          end
        end
      end
      S_WDATA: begin
        wsr_d     = {scan_in, wsr_q[DATA_W-2:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (word_last) begin
          bit_cnt_d   = '0;
          mem_en_d    = ~cmd_err_q;
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr_q;
          mem_wdata_d = wword;
          cur_addr_d  = addr_inc(cur_addr_q);
          // In fill mode rem keeps COUNT: the remaining fill writes.
          if (!fill_q && rem_q != '0) rem_d = rem_q - 1'b1;
        end
      end
      S_FILL: begin
        mem_en_d   = ~cmd_err_q;
        mem_we_d   = 1'b1;
        mem_addr_d = cur_addr_q;
        cur_addr_d = addr_inc(cur_addr_q);
        rem_d      = rem_q - 1'b1;
      end
      S_RCAP: begin
        rsr_d     = cmd_err_q ? '0 : mem.mem_rdata;
        bit_cnt_d = '0;
      end
      S_RSHIFT: begin
        rsr_d     = rsr_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (prefetch && rem_q != '0) begin
          mem_en_d   = ~cmd_err_q;
          mem_addr_d = cur_addr_q;
          cur_addr_d = addr_inc(cur_addr_q);
        end
        if (word_last) begin
          bit_cnt_d = '0;
          if (rem_q != '0) begin
            rsr_d = cmd_err_q ? '0 : mem.mem_rdata;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
    cmd_done_d = (state_d == S_IDLE) &&
                 (state_q == S_HDR || state_q == S_WDATA ||
                  state_q == S_FILL || state_q == S_RSHIFT);
  end

  // Outputs
  always_comb begin
    busy           = (state_q != S_IDLE);
    scan_out_valid = (state_q == S_RSHIFT);
    scan_out       = (state_q == S_RSHIFT) & rsr_q[0];
  end

  assign cmd_done      = cmd_done_q;
  assign frame_err     = frame_err_q;
  assign mem.mem_en    = mem_en_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sram_scan_bridge.sv
module tb_sram_scan_bridge;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1024;

  logic scan_clk = 1'b0;
  logic scan_rst = 1'b1;
  logic scan_in  = 1'b0;
  logic scan_out, scan_out_valid, busy, cmd_done, frame_err;

  sram_scan_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  sram_scan_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .scan_clk       (scan_clk),
    .scan_rst       (scan_rst),
    .scan_in        (scan_in),
    .scan_out       (scan_out),
    .scan_out_valid (scan_out_valid),
    .busy           (busy),
    .cmd_done       (cmd_done),
    .frame_err      (frame_err),
    .mem            (mem_bus)
  );

  always #5 scan_clk = ~scan_clk;

  int cyc = 0;
  always @(posedge scan_clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM, registered read
  logic [DATA_W-1:0] sram [0:DEPTH-1];
  always @(posedge scan_clk) begin
    if (mem_bus.mem_en) begin
      if (mem_bus.mem_we) sram[mem_bus.mem_addr % DEPTH] <= mem_bus.mem_wdata;
      else mem_bus.mem_rdata <= sram[mem_bus.mem_addr % DEPTH];
    end
  end

  // Monitor of SRAM writes, strobes, done pulses and read-back bits
  typedef struct { int a; logic [DATA_W-1:0] d; int c; logic b; } wr_t;
  wr_t  wq[$];
  logic rbits[$];
  int   en_cnt = 0, done_cnt = 0, vbits = 0, vfirst = 0, vlast = 0;

  always @(negedge scan_clk) begin
    if (mem_bus.mem_en) begin
      en_cnt++;
      if (mem_bus.mem_we)
        wq.push_back('{a: int'(mem_bus.mem_addr), d: mem_bus.mem_wdata, c: cyc, b: busy});
    end
    if (cmd_done) done_cnt++;
    if (scan_out_valid) begin
      if (vbits == 0) vfirst = cyc;
      vlast = cyc;
      rbits.push_back(scan_out);
      vbits++;
    end
  end

  int n_checks = 0, n_pass = 0;
  int last_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    wq.delete();
    rbits.delete();
    en_cnt = 0; done_cnt = 0; vbits = 0; vfirst = 0; vlast = 0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge scan_clk);
      scan_in = v[i];
    end
    last_cyc = cyc;
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [CNT_W-1:0] cnt);
    $display("tx op=%0d addr=%0h count=%0d", op, addr, cnt);
    send_bits(64'd1, 1);
    send_bits(64'(op), 2);
    send_bits(64'(addr), ADDR_W);
    send_bits(64'(cnt), CNT_W);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge scan_clk);
    scan_in = 1'b0;
    while (busy && k < budget) begin
      @(negedge scan_clk);
      k++;
    end
    check_eq({tag, "_idle"}, 64'(k < budget), 64'd1);
    repeat (2) @(negedge scan_clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rword(input int w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = rbits[w*DATA_W + i];
    return r;
  endfunction

  logic [DATA_W-1:0] t2w [3];
  int exp_c [3];
  int hdr_c, bad;
  logic [DATA_W-1:0] orv;

  initial begin
    t2w[0] = 32'hA5A5A5A5; t2w[1] = 32'h1; t2w[2] = 32'h2;
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;

    // 1: reset state, then reset in the middle of write data
    repeat (3) @(negedge scan_clk);
    #1;
    check_eq("rst_outputs", {scan_out, scan_out_valid, busy, cmd_done, frame_err,
             mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, 64'd0);
    @(negedge scan_clk);
    scan_rst = 1'b0;
    #1 clear_mon();
    send_hdr(2'b01, 11'h020, 8'd0);
    send_bits(64'h0000_BEEF, 16);
    @(negedge scan_clk);
    scan_rst = 1'b1;
    scan_in  = 1'b0;
    repeat (3) @(negedge scan_clk);
    #1;
    check_eq("midrst_outputs", {scan_out, scan_out_valid, busy, cmd_done, frame_err,
             mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, 64'd0);
    @(negedge scan_clk);
    scan_rst = 1'b0;
    repeat (4) @(negedge scan_clk);
    #1;
    check_eq("midrst_no_mem_en", 64'(en_cnt), 64'd0);
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);

    // 2: three-word write burst, then read it back
    clear_mon();
    send_hdr(2'b01, 11'h010, 8'd2);
    for (int w = 0; w < 3; w++) begin
      send_bits(64'(t2w[w]), DATA_W);
      exp_c[w] = last_cyc + 1;
    end
    wait_idle("t2w", 200);
    check_eq("t2_nwrites", 64'(wq.size()), 64'd3);
    for (int w = 0; w < 3 && w < wq.size(); w++) begin
      check_eq($sformatf("t2_addr%0d", w), 64'(wq[w].a), 64'(11'h010 + w));
      check_eq($sformatf("t2_data%0d", w), 64'(wq[w].d), 64'(t2w[w]));
      check_eq($sformatf("t2_cyc%0d", w), 64'(wq[w].c), 64'(exp_c[w]));
    end
    check_eq("t2_done", 64'(done_cnt), 64'd1);

    clear_mon();
    send_hdr(2'b10, 11'h010, 8'd2);
    hdr_c = last_cyc;
    wait_idle("t2r", 300);
    check_eq("t2r_nbits", 64'(vbits), 64'd96);
    check_eq("t2r_first", 64'(vfirst), 64'(hdr_c + 3));
    check_eq("t2r_span", 64'(vlast - vfirst), 64'd95);
    for (int w = 0; w < 3; w++)
      check_eq($sformatf("t2r_word%0d", w), 64'(rword(w)), 64'(t2w[w]));
    check_eq("t2r_done", 64'(done_cnt), 64'd1);

    // 3: address wrap at the top of the array
    clear_mon();
    send_hdr(2'b01, 11'h3FF, 8'd1);
    send_bits(64'h1111_1111, DATA_W);
    send_bits(64'h2222_2222, DATA_W);
    wait_idle("t3", 200);
    check_eq("t3_nwrites", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      check_eq("t3_addr0", 64'(wq[0].a), 64'h3FF);
      check_eq("t3_addr1", 64'(wq[1].a), 64'h000);
      check_eq("t3_data1", 64'(wq[1].d), 64'h2222_2222);
    end

    // 4: fill 16 words
    clear_mon();
    send_hdr(2'b11, 11'h100, 8'd15);
    send_bits(64'hDEAD_BEEF, DATA_W);
    exp_c[0] = last_cyc + 1;
    wait_idle("t4", 200);
    check_eq("t4_nwrites", 64'(wq.size()), 64'd16);
    if (wq.size() == 16) begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (wq[i].a != 32'h100 + i || wq[i].d != 32'hDEAD_BEEF || wq[i].c != exp_c[0] + i) bad++;
      check_eq("t4_seq_bad", 64'(bad), 64'd0);
      check_eq("t4_busy", 64'(wq[0].b), 64'd1);
      check_eq("t4_last_addr", 64'(wq[15].a), 64'h10F);
    end
    check_eq("t4_done", 64'(done_cnt), 64'd1);

    // 5: out-of-range read sets sticky error, returns zeros
    clear_mon();
    send_hdr(2'b10, 11'h400, 8'd0);
    wait_idle("t5", 200);
    check_eq("t5_frame_err", 64'(frame_err), 64'd1);
    check_eq("t5_no_mem_en", 64'(en_cnt), 64'd0);
    check_eq("t5_nbits", 64'(vbits), 64'd32);
    orv = '0;
    for (int i = 0; i < rbits.size(); i++) orv[0] = orv[0] | rbits[i];
    check_eq("t5_zero_bits", 64'(orv), 64'd0);
    send_hdr(2'b00, 11'h000, 8'd0);
    wait_idle("t5n", 50);
    check_eq("t5_sticky", 64'(frame_err), 64'd1);

    // 6: NOP then back-to-back single-word READ
    clear_mon();
    send_hdr(2'b00, 11'h000, 8'd0);
    send_hdr(2'b10, 11'h010, 8'd0);
    hdr_c = last_cyc;
    wait_idle("t6", 200);
    check_eq("t6_done", 64'(done_cnt), 64'd2);
    check_eq("t6_nbits", 64'(vbits), 64'd32);
    check_eq("t6_first", 64'(vfirst), 64'(hdr_c + 3));
    check_eq("t6_word", 64'(rword(0)), 64'hA5A5_A5A5);
    check_eq("t6_sticky", 64'(frame_err), 64'd1);

    // reset clears the sticky error
    @(negedge scan_clk);
    scan_rst = 1'b1;
    repeat (2) @(negedge scan_clk);
    scan_rst = 1'b0;
    @(negedge scan_clk);
    #1;
    check_eq("final_err_clear", 64'(frame_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
